// File: rtl/mem_access_stage.sv
// Memory-access stage: decodes lw/sw in XM and runs one req/ack transaction to the data memory.
// Latency: non-memory ops pass through in zero cycles; lw/sw take IDLE + BUSY (one or more cycles) + DONE.
// Backpressure: mem_stall freezes PC/FD/DX/XM while a transaction is pending; MW_en pulses in DONE.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   XM_IR/XM_output/XM_B    instruction, effective address and store data from the XM latch
//   XM_valid                XM holds a real instruction (0 = bubble)
//   dmem_req/we/addr/wdata  registered request to the data memory, stable while BUSY
//   dmem_ack/dmem_rdata     single-cycle completion pulse with load data
//   q_dmem                  captured load data for the MW data register
//   mem_stall, MW_en        upstream freeze and MW latch enable (MW_en = ~mem_stall)
//   mem_err                 sticky timeout flag
//
// Optional build macro MEM_TIMEOUT_EN: abort a BUSY transaction after TIMEOUT cycles
// without ack (load data reads 32'hDEADBEEF, mem_err set). Without it BUSY waits forever
// and mem_err is tied low. ADDR_W must be less than 32.

module mem_access_stage #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       XM_IR,
    input  logic [31:0]       XM_output,
    input  logic [31:0]       XM_B,
    input  logic              XM_valid,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic [31:0]       q_dmem,
    output logic              mem_stall,
    output logic              MW_en,
    output logic              mem_err
);

    localparam logic [4:0] OP_SW = 5'b00111;
    localparam logic [4:0] OP_LW = 5'b01000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                stall_c;

    logic [4:0] opcode;
    logic       is_sw, is_lw, mem_op;

    assign opcode = XM_IR[31:27];
    assign is_sw  = XM_valid & (opcode == OP_SW);
    assign is_lw  = XM_valid & (opcode == OP_LW);
    assign mem_op = is_sw | is_lw;

    // Only the opcode and the low address bits matter to this stage.
    logic unused_bits;
    assign unused_bits = ^{XM_IR[26:0], XM_output[31:ADDR_W]};

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        stall_c = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                stall_c = mem_op;
                if (mem_op) begin
                    addr_d  = XM_output[ADDR_W-1:0];
                    wdata_d = XM_B;
                    we_d    = is_sw;
                    req_d   = 1'b1;
                    state_d = BUSY;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                // An ack in the same cycle as the timeout completes normally.
                if (dmem_ack) begin
                    if (!we_q) begin
                        rdata_d = dmem_rdata;
                    end
                    req_d   = 1'b0;
                    state_d = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                // cnt_q counts completed ack-less BUSY cycles, so this fires in BUSY cycle TIMEOUT.
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    if (!we_q) begin
                        rdata_d = 32'hDEAD_BEEF;
                    end
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                // XM still holds the finished instruction; returning to IDLE
                // without looking at it keeps it from issuing again.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign mem_err = err_q;
`else
    assign mem_err = 1'b0;
`endif

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign q_dmem     = rdata_q;
    assign mem_stall  = stall_c;
    assign MW_en      = ~stall_c;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed instruction stream with a per-instruction timeline model.
// Latency: expectations are derived per cycle offset within each instruction's occupancy.
// Backpressure: a new XM instruction is presented only after the cycle in which MW_en is expected high.
`timescale 1ns/1ps

module tb_mem_access_stage;

    localparam int ADDR_W = 12;
    localparam int TMO    = 4;
    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SW  = 5'b00111;
    localparam logic [4:0] OP_LW  = 5'b01000;

    logic              clock = 1'b0;
    logic              reset;
    logic [31:0]       XM_IR, XM_output, XM_B;
    logic              XM_valid;
    logic              dmem_req, dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic              dmem_ack;
    logic [31:0]       dmem_rdata;
    logic [31:0]       q_dmem;
    logic              mem_stall, MW_en, mem_err;

    always #5 clock = ~clock;

    mem_access_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
        .clock      (clock),
        .reset      (reset),
        .XM_IR      (XM_IR),
        .XM_output  (XM_output),
        .XM_B       (XM_B),
        .XM_valid   (XM_valid),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .q_dmem     (q_dmem),
        .mem_stall  (mem_stall),
        .MW_en      (MW_en),
        .mem_err    (mem_err)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural model state (what the stage has committed so far).
    logic              m_we, m_err;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata, m_q;

    // Per-cycle expectations, published by the driver and checked by the compare process.
    logic              chk_en = 1'b0;
    logic              e_req, e_we, e_stall, e_err;
    logic [ADDR_W-1:0] e_addr;
    logic [31:0]       e_wdata, e_q;

    always @(negedge clock) begin
        if (chk_en) begin
            check("dmem_req",   {31'd0, dmem_req},  {31'd0, e_req});
            check("dmem_we",    {31'd0, dmem_we},   {31'd0, e_we});
            check("dmem_addr",  {20'd0, dmem_addr}, {20'd0, e_addr});
            check("dmem_wdata", dmem_wdata,         e_wdata);
            check("q_dmem",     q_dmem,             e_q);
            check("mem_stall",  {31'd0, mem_stall}, {31'd0, e_stall});
            check("MW_en",      {31'd0, MW_en},     {31'd0, !e_stall});
            check("mem_err",    {31'd0, mem_err},   {31'd0, e_err});
        end
    end

    // Request monitor: counts rising edges of dmem_req and records their addresses.
    int                req_edges = 0;
    logic              req_prev  = 1'b0;
    logic [ADDR_W-1:0] req_addrs[$];

    always @(negedge clock) begin
        if (dmem_req && !req_prev) begin
            req_edges++;
            req_addrs.push_back(dmem_addr);
        end
        req_prev = dmem_req;
    end

    task automatic model_clear();
        m_we = 1'b0; m_err = 1'b0; m_addr = '0; m_wdata = '0; m_q = '0;
    endtask

    task automatic publish(input logic req, input logic stall);
        e_req = req; e_stall = stall;
        e_we = m_we; e_addr = m_addr; e_wdata = m_wdata; e_q = m_q; e_err = m_err;
    endtask

    // Hold reset for two cycles with a bubble in XM, then release with the model cleared.
    task automatic apply_reset();
        chk_en    = 1'b0;
        reset     = 1'b0;
        XM_valid  = 1'b0;
        dmem_ack  = 1'b0;
        repeat (2) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        model_clear();
        publish(1'b0, 1'b0);
        chk_en = 1'b1;
    endtask

    // Present one instruction in XM for its whole occupancy. ack_at is the BUSY cycle
    // (1-based) in which memory acks; 0 means never. Called and returns at posedge+1.
    task automatic run_instr(input logic [4:0] op, input logic valid,
                             input logic [31:0] addr, input logic [31:0] b,
                             input int ack_at, input logic [31:0] rdata, input bit spurious,
                             output int stall_n, output int req_n, output int mwen_n);
        bit is_mem, is_sw, tmo;
        int n_eff, total;
        is_sw  = valid && (op == OP_SW);
        is_mem = is_sw || (valid && (op == OP_LW));
        tmo    = 1'b0;
        n_eff  = ack_at;
`ifdef MEM_TIMEOUT_EN
        if (ack_at == 0 || ack_at > TMO) begin
            tmo   = 1'b1;
            n_eff = TMO;
        end
`endif
        total   = is_mem ? n_eff + 2 : 1;
        stall_n = 0; req_n = 0; mwen_n = 0;
        for (int k = 0; k < total; k++) begin
            XM_IR      = {op, 27'h2A5_A5A5};
            XM_output  = addr;
            XM_B       = b;
            XM_valid   = valid;
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
            if (is_mem && !tmo && k == n_eff) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            if (spurious && (k == 0 || k == total - 1)) begin
                dmem_ack = 1'b1;
            end
            if (is_mem && k == 1) begin
                m_we = is_sw; m_addr = addr[ADDR_W-1:0]; m_wdata = b;
            end
            if (is_mem && k == n_eff + 1) begin
                if (!is_sw) m_q = tmo ? 32'hDEAD_BEEF : rdata;
                if (tmo) m_err = 1'b1;
            end
            publish(is_mem && k >= 1 && k <= n_eff, is_mem && k <= n_eff);
            @(negedge clock);
            stall_n += int'(mem_stall);
            req_n   += int'(dmem_req);
            mwen_n  += int'(MW_en);
            @(posedge clock); #1;
        end
        dmem_ack = 1'b0;
    endtask

    int s_n, r_n, w_n, edges0;

    initial begin
        reset = 1'b0; XM_IR = '0; XM_output = '0; XM_B = '0; XM_valid = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        #12;
        check("rst_req",   {31'd0, dmem_req},  32'd0);
        check("rst_we",    {31'd0, dmem_we},   32'd0);
        check("rst_addr",  {20'd0, dmem_addr}, 32'd0);
        check("rst_wdata", dmem_wdata,         32'd0);
        check("rst_q",     q_dmem,             32'd0);
        check("rst_err",   {31'd0, mem_err},   32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        model_clear();
        publish(1'b0, 1'b0);
        chk_en = 1'b1;

        // add passes straight through, with a stray ack thrown in.
        run_instr(OP_ADD, 1'b1, 32'h0000_0100, 32'h1, 0, '0, 1'b1, s_n, r_n, w_n);
        check("add_stall_cycles", s_n, 0);
        check("add_req_cycles",   r_n, 0);
        check("add_mwen_cycles",  w_n, 1);

        // lw 0x010, ack in the third BUSY cycle.
        run_instr(OP_LW, 1'b1, 32'h0000_0010, 32'h0, 3, 32'h1234_5678, 1'b0, s_n, r_n, w_n);
        check("lw_stall_cycles", s_n, 4);
        check("lw_req_cycles",   r_n, 3);
        check("lw_mwen_pulses",  w_n, 1);
        check("lw_q_dmem",       q_dmem, 32'h1234_5678);

        // sw with upper address bits set, immediate ack; load data register untouched.
        run_instr(OP_SW, 1'b1, 32'hABCD_E020, 32'hCAFE_F00D, 1, 32'h5555_AAAA, 1'b0, s_n, r_n, w_n);
        check("sw_stall_cycles", s_n, 2);
        check("sw_req_cycles",   r_n, 1);
        check("sw_wdata",        dmem_wdata, 32'hCAFE_F00D);
        check("sw_addr",         {20'd0, dmem_addr}, 32'h020);
        check("sw_we",           {31'd0, dmem_we}, 32'd1);
        check("sw_q_unchanged",  q_dmem, 32'h1234_5678);

        // lw then sw back-to-back, spurious acks in IDLE/DONE cycles.
        edges0 = req_edges;
        req_addrs.delete();
        run_instr(OP_LW, 1'b1, 32'h0000_0030, 32'h0, 1, 32'hA5A5_A5A5, 1'b1, s_n, r_n, w_n);
        run_instr(OP_SW, 1'b1, 32'h0000_0040, 32'h1111_2222, 2, 32'h0, 1'b1, s_n, r_n, w_n);
        check("b2b_req_count", req_edges - edges0, 2);
        if (req_addrs.size() == 2) begin
            check("b2b_first_addr",  {20'd0, req_addrs[0]}, 32'h030);
            check("b2b_second_addr", {20'd0, req_addrs[1]}, 32'h040);
        end else begin
            check("b2b_addr_log_size", req_addrs.size(), 2);
        end
        check("b2b_q_dmem", q_dmem, 32'hA5A5_A5A5);

        // Bubble carrying a lw opcode is not a memory op.
        run_instr(OP_LW, 1'b0, 32'h0000_0050, 32'h0, 1, 32'h0, 1'b0, s_n, r_n, w_n);
        check("bubble_stall_cycles", s_n, 0);
        check("bubble_req_cycles",   r_n, 0);

`ifdef MEM_TIMEOUT_EN
        // No ack: abort after TMO BUSY cycles.
        run_instr(OP_LW, 1'b1, 32'h0000_0060, 32'h0, 0, 32'h0, 1'b0, s_n, r_n, w_n);
        check("tmo_req_cycles", r_n, 4);
        check("tmo_q_dmem",     q_dmem, 32'hDEAD_BEEF);
        check("tmo_err",        {31'd0, mem_err}, 32'd1);
        run_instr(OP_ADD, 1'b1, 32'h0, 32'h0, 0, 32'h0, 1'b0, s_n, r_n, w_n);
        check("tmo_err_sticky", {31'd0, mem_err}, 32'd1);
        apply_reset();
        // Ack lands in the timeout cycle: normal completion.
        run_instr(OP_LW, 1'b1, 32'h0000_0070, 32'h0, 4, 32'h0BAD_F00D, 1'b0, s_n, r_n, w_n);
        check("ack4_req_cycles", r_n, 4);
        check("ack4_q_dmem",     q_dmem, 32'h0BAD_F00D);
        check("ack4_err",        {31'd0, mem_err}, 32'd0);
`else
        // Without the timeout a long ack wait just keeps the request up.
        run_instr(OP_LW, 1'b1, 32'h0000_0060, 32'h0, 8, 32'h7654_3210, 1'b0, s_n, r_n, w_n);
        check("long_req_cycles",   r_n, 8);
        check("long_stall_cycles", s_n, 9);
        check("long_q_dmem",       q_dmem, 32'h7654_3210);
        check("long_err",          {31'd0, mem_err}, 32'd0);
`endif

        // Reset in the middle of a BUSY wait.
        chk_en    = 1'b0;
        XM_IR     = {OP_LW, 27'h0};
        XM_output = 32'h0000_0080;
        XM_valid  = 1'b1;
        dmem_ack  = 1'b0;
        @(posedge clock); #1;     // first BUSY cycle
        XM_valid = 1'b0;
        @(posedge clock); #1;     // second BUSY cycle
        check("mid_req_before_reset", {31'd0, dmem_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, dmem_req}, 32'd0);
        check("mid_rst_q",   q_dmem,            32'd0);
        check("mid_rst_err", {31'd0, mem_err},  32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        model_clear();
        // Late ack from the aborted transaction must be ignored.
        run_instr(OP_ADD, 1'b0, 32'h0, 32'h0, 0, 32'h0, 1'b1, s_n, r_n, w_n);
        check("post_rst_stall", s_n, 0);
        check("post_rst_req",   r_n, 0);
        check("post_rst_q",     q_dmem, 32'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
